// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM state
// encoding, status register bit positions and the default SoC addresses.
package uart_pkg;

    // Default slots in the open_risc_v_soc address map.
    localparam logic [31:0] UART_DATA_ADDR = 32'h3000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h3000_0004;

    // Transmit FSM states; PARITY is only reachable in the parity build.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Status register layout (identical in both builds).
    localparam int STAT_FULL    = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_EMPTY   = 3;
    localparam int STAT_CNT_LSB = 8;

    // Even parity: set when the byte holds an odd number of ones.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter. Head entry is visible on dout
// combinationally; push is refused when full and pop when empty, so the
// caller can strobe freely. Fullness is judged on the pre-edge count.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: address decode on the core's write/read
// buses, status/overflow flag, baud counter and the 8N1 serialiser.
// Build option: define UART_TX_PARITY_EN for 8E1 framing (even parity bit
// after the data bits); otherwise frames are 8N1.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ   = 50_000_000,
    parameter int          BAUD       = 115_200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] DATA_ADDR  = UART_DATA_ADDR,
    parameter logic [31:0] STAT_ADDR  = UART_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req_i,
    input  logic [3:0]  wr_sel_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        rd_req_i,
    input  logic [31:0] rd_addr_i,
    output logic [31:0] rd_data_o,
    output logic        rd_hit_o,
    output logic        uart_txd,
    output logic        tx_busy_o
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    tx_state_t       state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            baud_wrap;
    logic            overflow;

    logic            push_req;
    logic            clr_req;
    logic            fifo_pop;
    logic [7:0]      fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     status;

`ifdef UART_TX_PARITY_EN
    logic            par_bit;
`endif

    // Only the low byte lane and bit 2 of the data bus matter here.
    logic            unused_bits;
    assign unused_bits = ^{wr_sel_i[3:1], wr_data_i[31:8]};

    assign push_req  = wr_req_i && (wr_addr_i == DATA_ADDR) && wr_sel_i[0];
    assign clr_req   = wr_req_i && (wr_addr_i == STAT_ADDR) && wr_sel_i[0] && wr_data_i[2];
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign baud_wrap = (baud_cnt == BW'(DIV - 1));
    assign tx_busy_o = (state != ST_IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (wr_data_i[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow: a dropped push wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)                        overflow <= 1'b0;
        else if (push_req && fifo_full) overflow <= 1'b1;
        else if (clr_req)               overflow <= 1'b0;
    end

    // Status word and read decode, combinational in the request cycle.
    always_comb begin
        status                          = '0;
        status[STAT_FULL]               = fifo_full;
        status[STAT_BUSY]               = tx_busy_o;
        status[STAT_OVF]                = overflow;
        status[STAT_EMPTY]              = fifo_empty;
        status[STAT_CNT_LSB +: 8]       = 8'(fifo_count);
        rd_hit_o                        = rd_req_i && (rd_addr_i == STAT_ADDR);
        rd_data_o                       = rd_hit_o ? status : 32'h0;
    end

    // Transmit FSM. txd is registered from the current state, so the line
    // lags the state by one clk; this gives the 2-clk push-to-start latency
    // and keeps every bit exactly DIV clks wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            uart_txd <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            if (state == ST_IDLE) baud_cnt <= '0;
            else                  baud_cnt <= baud_wrap ? '0 : baud_cnt + BW'(1);

            case (state)
                ST_IDLE: begin
                    uart_txd <= 1'b1;
                    if (!fifo_empty) begin
                        shift   <= fifo_dout;
                        bit_cnt <= '0;
                        state   <= ST_START;
`ifdef UART_TX_PARITY_EN
                        par_bit <= even_parity(fifo_dout);
`endif
                    end
                end
                ST_START: begin
                    uart_txd <= 1'b0;
                    if (baud_wrap) state <= ST_DATA;
                end
                ST_DATA: begin
                    uart_txd <= shift[0];
                    if (baud_wrap) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    uart_txd <= par_bit;
                    if (baud_wrap) state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    uart_txd <= 1'b1;
                    if (baud_wrap) state <= ST_IDLE;
                end
                default: begin
                    uart_txd <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
